// File: rtl/alu_ops_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ops_pkg
//  Description : ALU operation codes, ALUOp encodings and forward-select enum.
//  Revision    : 1.0
// ============================================================================
package alu_ops_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_UPPER  = 2'b11;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALUOp/funct3/funct7 decode to ALU operation.
//  Revision    : 1.0
// ============================================================================
module alu_decoder
    import alu_ops_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] operation
);

    always_comb begin
        operation = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000:         operation = ALU_BEQ;
                    3'b001:         operation = ALU_BNE;
                    3'b100, 3'b101: operation = ALU_SLT;
                    3'b110, 3'b111: operation = ALU_SLTU;
                    default:        operation = ALU_ADD;
                endcase
            end
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000:  operation = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  operation = ALU_SLL;
                    3'b010:  operation = ALU_SLT;
                    3'b011:  operation = ALU_SLTU;
                    3'b100:  operation = ALU_XOR;
                    3'b101:  operation = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  operation = ALU_OR;
                    default: operation = ALU_AND;
                endcase
            end
            default: operation = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with ALU decode, operand select,
//                stall/flush and optional MEM/WB forwarding
//                (enabled by defining ID_EX_FORWARDING_EN).
//  Revision    : 1.0
// ============================================================================
module id_ex_stage
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic                         id_stall,
    input  logic                         id_flush,
    input  logic [DATA_WIDTH-1:0]        id_pc,
    input  logic [DATA_WIDTH-1:0]        id_rs1_data,
    input  logic [DATA_WIDTH-1:0]        id_rs2_data,
    input  logic [DATA_WIDTH-1:0]        id_imm,
    input  logic [REG_ADDR_W-1:0]        id_rs1,
    input  logic [REG_ADDR_W-1:0]        id_rs2,
    input  logic [REG_ADDR_W-1:0]        id_rd,
    input  logic [1:0]                   id_alu_op,
    input  logic                         id_alusrc,
    input  logic                         id_srca_pc,
    input  logic                         id_is_rtype,
    input  logic [2:0]                   id_funct3,
    input  logic                         id_funct7b5,
    input  logic                         id_reg_write,
    input  logic [REG_ADDR_W-1:0]        mem_rd,
    input  logic                         mem_reg_write,
    input  logic [DATA_WIDTH-1:0]        mem_result,
    input  logic [REG_ADDR_W-1:0]        wb_rd,
    input  logic                         wb_reg_write,
    input  logic [DATA_WIDTH-1:0]        wb_result,
    output logic signed [DATA_WIDTH-1:0] SrcA,
    output logic signed [DATA_WIDTH-1:0] SrcB,
    output logic [OPCODE_LENGTH-1:0]     Operation,
    output logic                         ex_valid,
    output logic                         ex_reg_write,
    output logic [REG_ADDR_W-1:0]        ex_rd,
    output logic [2:0]                   ex_funct3,
    output logic [DATA_WIDTH-1:0]        ex_store_data
);

    logic [DATA_WIDTH-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
    logic [1:0]            alu_op_q;
    logic                  alusrc_q, srca_pc_q, is_rtype_q, funct7b5_q;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
    logic [3:0]            dec_op;

`ifdef ID_EX_FORWARDING_EN
    fwd_sel_t sel_a, sel_b;

    // A matching rd is necessarily nonzero once rs is known to be nonzero.
    function automatic fwd_sel_t pick(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (rs == '0)              return FWD_NONE;
        if (m_we && (m_rd == rs))  return FWD_MEM;
        if (w_we && (w_rd == rs))  return FWD_WB;
        return FWD_NONE;
    endfunction

    always_comb begin
        sel_a = pick(rs1_q, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        sel_b = pick(rs2_q, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        case (sel_a)
            FWD_MEM: fwd_a = mem_result;
            FWD_WB:  fwd_a = wb_result;
            default: fwd_a = rs1_data_q;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = mem_result;
            FWD_WB:  fwd_b = wb_result;
            default: fwd_b = rs2_data_q;
        endcase
    end
`else
    logic unused_fwd_inputs;
    assign fwd_a = rs1_data_q;
    assign fwd_b = rs2_data_q;
    assign unused_fwd_inputs = ^{mem_rd, mem_reg_write, mem_result,
                                 wb_rd, wb_reg_write, wb_result};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset || id_flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            alu_op_q     <= '0;
            alusrc_q     <= 1'b0;
            srca_pc_q    <= 1'b0;
            is_rtype_q   <= 1'b0;
            funct7b5_q   <= 1'b0;
        end else if (id_stall) begin
`ifdef ID_EX_FORWARDING_EN
            // Keep operands current so a producer retiring mid-stall is not lost.
            rs1_data_q <= fwd_a;
            rs2_data_q <= fwd_b;
`endif
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write;
            ex_rd        <= id_rd;
            ex_funct3    <= id_funct3;
            pc_q         <= id_pc;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            alu_op_q     <= id_alu_op;
            alusrc_q     <= id_alusrc;
            srca_pc_q    <= id_srca_pc;
            is_rtype_q   <= id_is_rtype;
            funct7b5_q   <= id_funct7b5;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op_q),
        .funct3    (ex_funct3),
        .funct7b5  (funct7b5_q),
        .is_rtype  (is_rtype_q),
        .operation (dec_op)
    );

    assign Operation     = OPCODE_LENGTH'(dec_op);
    assign SrcA          = srca_pc_q ? pc_q : fwd_a;
    assign SrcB          = alusrc_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (vectors, corners, random).
//  Revision    : 1.0
// ============================================================================
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_stall, id_flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic        id_alusrc, id_srca_pc, id_is_rtype, id_funct7b5, id_reg_write;
    logic [2:0]  id_funct3;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic signed [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_store_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_stall(id_stall),
        .id_flush(id_flush), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alusrc(id_alusrc), .id_srca_pc(id_srca_pc),
        .id_is_rtype(id_is_rtype), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_store_data(ex_store_data)
    );

    typedef struct packed {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  alu_op;
        logic        alusrc, srca_pc, rtype, f7, rw, valid;
        logic [2:0]  f3;
    } ex_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
    } wr_t;

    typedef struct packed {
        ex_t         id;
        wr_t         mem;
        wr_t         wb;
        logic [3:0]  e_op;
        logic [31:0] e_a_fwd, e_a_plain, e_b, e_store;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input ex_t e);
        id_pc = e.pc; id_rs1_data = e.a; id_rs2_data = e.b; id_imm = e.imm;
        id_rs1 = e.rs1; id_rs2 = e.rs2; id_rd = e.rd; id_alu_op = e.alu_op;
        id_alusrc = e.alusrc; id_srca_pc = e.srca_pc; id_is_rtype = e.rtype;
        id_funct7b5 = e.f7; id_reg_write = e.rw; id_valid = e.valid; id_funct3 = e.f3;
    endtask

    task automatic drive_wr(input wr_t m, input wr_t w);
        mem_reg_write = m.we; mem_rd = m.rd; mem_result = m.res;
        wb_reg_write  = w.we; wb_rd  = w.rd; wb_result  = w.res;
    endtask

    // Operation expected from the instruction class and its function fields.
    function automatic logic [3:0] model_op(input ex_t e);
        logic [3:0] arith [8];
        arith = '{4'b0010, 4'b0100, 4'b0101, 4'b1100, 4'b0110, 4'b0111, 4'b0001, 4'b0000};
        case (e.alu_op)
            2'b01: begin
                if (e.f3[2]) return e.f3[1] ? 4'b1100 : 4'b0101;
                return e.f3[0] ? 4'b1011 : 4'b1010;
            end
            2'b10: begin
                if (e.f3 == 3'd0 && e.rtype && e.f7) return 4'b0011;
                if (e.f3 == 3'd5 && e.f7) return 4'b1000;
                return arith[e.f3];
            end
            default: return 4'b0010;
        endcase
    endfunction

    // Youngest in-flight writer of a nonzero register supplies the value.
    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] regval);
        wr_t writers [2];
        if (!FWD || rs == 5'd0) return regval;
        writers[0] = '{mem_reg_write, mem_rd, mem_result};
        writers[1] = '{wb_reg_write, wb_rd, wb_result};
        foreach (writers[i])
            if (writers[i].we && writers[i].rd == rs) return writers[i].res;
        return regval;
    endfunction

    task automatic check_model(input string nm, input ex_t m);
        logic [31:0] fa, fb;
        fa = model_fwd(m.rs1, m.a);
        fb = model_fwd(m.rs2, m.b);
        chk({nm, ".op"},    32'(Operation),    32'(model_op(m)));
        chk({nm, ".srca"},  SrcA,              m.srca_pc ? m.pc : fa);
        chk({nm, ".srcb"},  SrcB,              m.alusrc ? m.imm : fb);
        chk({nm, ".store"}, ex_store_data,     fb);
        chk({nm, ".valid"}, 32'(ex_valid),     32'(m.valid));
        chk({nm, ".rw"},    32'(ex_reg_write), 32'(m.rw));
        chk({nm, ".rd"},    32'(ex_rd),        32'(m.rd));
        chk({nm, ".f3"},    32'(ex_funct3),    32'(m.f3));
    endtask

    vec_t vecs [9];
    ex_t  s, j, m, r;
    vec_t v;
    logic [31:0] fa, fb;

    initial begin
        // ---------------- vector table ----------------
        v = '0; v.id.rs1 = 1; v.id.rs2 = 2; v.id.rd = 3; v.id.a = 10; v.id.b = 3;
        v.id.alu_op = 2'b10; v.id.f7 = 1; v.id.rtype = 1; v.id.rw = 1; v.id.valid = 1;
        v.e_op = 4'b0011; v.e_a_fwd = 10; v.e_a_plain = 10; v.e_b = 3; v.e_store = 3;
        vecs[0] = v;
        v = '0; v.id.rs1 = 1; v.id.a = 32'h8000_0000; v.id.rs2 = 2; v.id.b = 9; v.id.imm = 4;
        v.id.alusrc = 1; v.id.alu_op = 2'b10; v.id.f3 = 3'd5; v.id.f7 = 1; v.id.rw = 1;
        v.id.valid = 1; v.id.rd = 4;
        v.e_op = 4'b1000; v.e_a_fwd = 32'h8000_0000; v.e_a_plain = 32'h8000_0000; v.e_b = 4; v.e_store = 9;
        vecs[1] = v;
        v = '0; v.id.alu_op = 2'b01; v.id.f3 = 3'd6; v.id.a = 5; v.id.b = 7; v.id.rs1 = 1;
        v.id.rs2 = 2; v.id.valid = 1;
        v.e_op = 4'b1100; v.e_a_fwd = 5; v.e_a_plain = 5; v.e_b = 7; v.e_store = 7;
        vecs[2] = v;
        v = '0; v.id.rs1 = 5; v.id.a = 32'h11; v.id.b = 32'h22; v.id.alu_op = 2'b10;
        v.id.valid = 1; v.id.rw = 1; v.id.rd = 6;
        v.mem = '{1'b1, 5'd5, 32'hAA}; v.wb = '{1'b1, 5'd5, 32'hBB};
        v.e_op = 4'b0010; v.e_a_fwd = 32'hAA; v.e_a_plain = 32'h11; v.e_b = 32'h22; v.e_store = 32'h22;
        vecs[3] = v;
        v.mem.we = 1'b0; v.e_a_fwd = 32'hBB;
        vecs[4] = v;
        v.id.rs1 = 0; v.id.a = 32'h33; v.mem = '{1'b1, 5'd0, 32'hAA}; v.wb = '{1'b1, 5'd0, 32'hBB};
        v.e_a_fwd = 32'h33; v.e_a_plain = 32'h33;
        vecs[5] = v;
        v = '0; v.id.alu_op = 2'b11; v.id.srca_pc = 1; v.id.pc = 32'h1000; v.id.alusrc = 1;
        v.id.imm = 32'h5000; v.id.a = 32'h44; v.id.b = 32'h66; v.id.valid = 1; v.id.rw = 1; v.id.rd = 7;
        v.e_op = 4'b0010; v.e_a_fwd = 32'h1000; v.e_a_plain = 32'h1000; v.e_b = 32'h5000; v.e_store = 32'h66;
        vecs[6] = v;
        v = '0; v.id.alu_op = 2'b10; v.id.f7 = 1; v.id.alusrc = 1; v.id.imm = 32'hFFFF_FFFF;
        v.id.a = 7; v.id.valid = 1; v.id.rw = 1; v.id.rd = 8;
        v.e_op = 4'b0010; v.e_a_fwd = 7; v.e_a_plain = 7; v.e_b = 32'hFFFF_FFFF; v.e_store = 0;
        vecs[7] = v;
        v = '0; v.id.alu_op = 2'b01; v.id.f3 = 3'd1; v.id.a = 1; v.id.b = 2; v.id.valid = 1;
        v.e_op = 4'b1011; v.e_a_fwd = 1; v.e_a_plain = 1; v.e_b = 2; v.e_store = 2;
        vecs[8] = v;

        // ---------------- reset ----------------
        reset = 1'b1; id_stall = 1'b0; id_flush = 1'b0;
        drive_id('0); drive_wr('0, '0);
        #22;
        check_model("reset", '0);
        reset = 1'b0;
        step(); step();
        check_model("idle", '0);

        // ---------------- table-driven loads ----------------
        foreach (vecs[i]) begin
            drive_id(vecs[i].id);
            drive_wr(vecs[i].mem, vecs[i].wb);
            step();
            chk($sformatf("vec%0d.op", i),    32'(Operation), 32'(vecs[i].e_op));
            chk($sformatf("vec%0d.srca", i),  SrcA, FWD ? vecs[i].e_a_fwd : vecs[i].e_a_plain);
            chk($sformatf("vec%0d.srcb", i),  SrcB, vecs[i].e_b);
            chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].e_store);
            chk($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'(vecs[i].id.valid));
            chk($sformatf("vec%0d.rw", i),    32'(ex_reg_write), 32'(vecs[i].id.rw));
            chk($sformatf("vec%0d.rd", i),    32'(ex_rd), 32'(vecs[i].id.rd));
            chk($sformatf("vec%0d.f3", i),    32'(ex_funct3), 32'(vecs[i].id.f3));
        end

        // ---------------- stall with producer leaving WB ----------------
        drive_wr('0, '0);
        s = '0; s.valid = 1; s.rw = 1; s.rd = 9; s.rs1 = 4; s.a = 32'h77; s.rs2 = 7;
        s.b = 32'h01; s.alu_op = 2'b10; s.f3 = 3'd2;
        drive_id(s);
        step();
        j = '0; j.rd = 1; j.a = 32'hDEAD; j.b = 32'hBEEF; j.alu_op = 2'b01;
        drive_id(j);
        id_stall = 1'b1;
        drive_wr('0, '{1'b1, 5'd7, 32'h55});
        #1;
        chk("stall.c0.store", ex_store_data, FWD ? 32'h55 : 32'h01);
        for (int c = 1; c <= 3; c++) begin
            step();
            drive_wr('0, '{1'b0, 5'd0, 32'hDEAD});
            #1;
            chk($sformatf("stall.c%0d.store", c), ex_store_data, FWD ? 32'h55 : 32'h01);
            chk($sformatf("stall.c%0d.rd", c), 32'(ex_rd), 32'd9);
            chk($sformatf("stall.c%0d.op", c), 32'(Operation), 32'b0101);
            chk($sformatf("stall.c%0d.valid", c), 32'(ex_valid), 32'd1);
        end
        id_stall = 1'b0;

        // ---------------- stall + flush ----------------
        drive_id(s);
        step();
        id_stall = 1'b1; id_flush = 1'b1;
        step();
        chk("sf.valid", 32'(ex_valid), 32'd0);
        chk("sf.rw",    32'(ex_reg_write), 32'd0);
        chk("sf.srca",  SrcA, 32'd0);
        chk("sf.op",    32'(Operation), 32'b0010);
        id_flush = 1'b0; id_stall = 1'b0;

        // ---------------- reset mid-stall, asynchronous ----------------
        drive_id(s);
        step();
        id_stall = 1'b1;
        step();
        #3 reset = 1'b1;
        #1;
        chk("rst.valid", 32'(ex_valid), 32'd0);
        chk("rst.rw",    32'(ex_reg_write), 32'd0);
        chk("rst.srca",  SrcA, 32'd0);
        chk("rst.rd",    32'(ex_rd), 32'd0);
        chk("rst.op",    32'(Operation), 32'b0010);
        #2 reset = 1'b0;
        id_stall = 1'b0;
        step();
        chk("post_rst.valid", 32'(ex_valid), 32'd1);
        chk("post_rst.rd",    32'(ex_rd), 32'd9);

        // ---------------- randomized against the reference model ----------------
        id_flush = 1'b1;
        step();
        id_flush = 1'b0;
        m = '0;
        for (int c = 0; c < 300; c++) begin
            r = '0;
            r.pc = $urandom; r.a = $urandom; r.b = $urandom; r.imm = $urandom;
            r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
            r.rd = 5'($urandom_range(0, 31));
            r.alu_op = 2'($urandom); r.f3 = 3'($urandom);
            if (r.alu_op == 2'b01 && r.f3[2:1] == 2'b01) r.f3[1] = 1'b0;
            r.alusrc = 1'($urandom); r.srca_pc = 1'($urandom); r.rtype = 1'($urandom);
            r.f7 = 1'($urandom); r.rw = 1'($urandom); r.valid = 1'($urandom);
            drive_id(r);
            drive_wr('{1'($urandom), 5'($urandom_range(0, 3)), $urandom},
                     '{1'($urandom), 5'($urandom_range(0, 3)), $urandom});
            id_stall = ($urandom_range(0, 4) == 0);
            id_flush = ($urandom_range(0, 5) == 0);
            fa = model_fwd(m.rs1, m.a);
            fb = model_fwd(m.rs2, m.b);
            if (id_flush) m = '0;
            else if (id_stall) begin
                if (FWD) begin m.a = fa; m.b = fb; end
            end
            else m = r;
            step();
            check_model($sformatf("rnd%0d", c), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded instruction fields from ID and decodes ALUOp/funct3/funct7 into the 4-bit ALU `Operation` code. It selects `SrcA`/`SrcB` (register, immediate, PC), applies MEM/WB operand forwarding, and implements stall (hold) and flush (bubble) control.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width.
- `OPCODE_LENGTH`, 4: width of `Operation`.
- `REG_ADDR_W`, 5: register index width.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_stall`, in, 1: hold EX register contents.
- `id_flush`, in, 1: load a bubble.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`, in, DATA_WIDTH each: ID operands.
- `id_rs1`, `id_rs2`, `id_rd`, in, REG_ADDR_W each: register indices.
- `id_alu_op`, in, 2: 00 mem, 01 branch, 10 R/I arith, 11 upper-immediate.
- `id_alusrc`, in, 1: SrcB = immediate.
- `id_srca_pc`, in, 1: SrcA = PC (AUIPC/JAL).
- `id_is_rtype`, in, 1: funct7 bit applies to ADD/SUB.
- `id_funct3`, in, 3: instruction funct3.
- `id_funct7b5`, in, 1: instruction bit 30.
- `id_reg_write`, in, 1: instruction writes rd.
- `mem_rd`, in, REG_ADDR_W: MEM-stage destination.
- `mem_reg_write`, in, 1: MEM-stage writes rd.
- `mem_result`, in, DATA_WIDTH: MEM-stage value.
- `wb_rd`, `wb_reg_write`, `wb_result`: same three signals for WB.
- `SrcA`, `SrcB`, out, DATA_WIDTH, signed: ALU operands.
- `Operation`, out, OPCODE_LENGTH: ALU operation code.
- `ex_valid`, `ex_reg_write`, out, 1: registered valid and write-enable.
- `ex_rd`, out, REG_ADDR_W: registered destination.
- `ex_funct3`, out, 3: registered funct3, for branch sense and store size.
- `ex_store_data`, out, DATA_WIDTH: forwarded rs2 value.

## Operation
- Priority per edge: `reset` > `id_flush` > `id_stall` > load.
- Load: all ID fields are captured into the EX register.
- Flush: `ex_valid`=0 and `ex_reg_write`=0. Remaining fields are don't-care but are cleared to 0.
- Stall: control fields hold. The rs1/rs2 operand registers capture their current forwarded value (refresh-on-stall), so a producer that leaves WB during the stall is not lost.
- Decode (registered fields) to `Operation`:
  - alu_op 00 or 11: ADD 0010.
  - alu_op 01: funct3 000 gives BEQ 1010; 001 gives BNE 1011; 100/101 give SLT 0101; 110/111 give SLTU 1100.
  - alu_op 10: funct3 000 gives SUB 0011 if is_rtype & funct7b5, else ADD 0010.
  - alu_op 10: 001 gives SLL 0100; 010 gives SLT 0101; 011 gives SLTU 1100; 100 gives XOR 0110.
  - alu_op 10: 101 gives SRA 1000 if funct7b5, else SRL 0111; 110 gives OR 0001; 111 gives AND 0000.
- Forwarding, per operand, combinational from the registered rs index:
  - MEM match (reg_write, rd≠0, rd==rs) has priority over a WB match.
  - Otherwise the registered register-file data is used.
  - rs==0 always yields the registered value.
- Operand select:
  - `SrcA` = srca_pc ? pc : fwdA.
  - `SrcB` = alusrc ? imm : fwdB.
  - `ex_store_data` = fwdB.
- The register file write-through covers the ID/WB same-cycle case; this block does not forward into ID.

## Timing
- Reset: all registers 0. `ex_valid`=0, `ex_reg_write`=0, `Operation`=4'b0010 (ADD of zeros), `SrcA`=`SrcB`=0.
- Latency: ID inputs at edge N appear on outputs after edge N; `Operation` is combinational from registered fields.
- Forwarding paths are combinational, MEM/WB inputs to `SrcA`/`SrcB` in the same cycle.
- Simultaneous stall+flush: the flush wins.
- Reset asserted mid-stall: the registers clear immediately (asynchronous).
- Edge following reset deassertion: normal loading.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding muxes and refresh-on-stall are present.
- Undefined: fwdA/fwdB equal the registered register-file data. The mem_/wb_ inputs are unused. Stall holds all fields unchanged. Hazards are resolved by stalling upstream.

## Structure
- Package `alu_ops_pkg`:
  - `Operation` code localparams matching the ALU: AND, OR, ADD, SUB, SLL, SLT, XOR, SRL, SRA, NOR, BEQ, BNE, SLTU.
  - `alu_op` encodings.
  - Forward-select enum (NONE/MEM/WB).
- Sub-module `alu_decoder`: combinational alu_op/funct3/funct7b5/is_rtype to `Operation`.

## Test plan
- Reset, then release with no activity: `ex_valid`=0, `Operation`=0010, `SrcA`=`SrcB`=0.
- Load R-type funct3=000, funct7b5=1, rs1_data=10, rs2_data=3: `Operation`=0011, `SrcA`=10, `SrcB`=3, `ex_valid`=1 after one edge.
- Load I-type SRAI funct3=101, funct7b5=1, alusrc=1, imm=4: `Operation`=1000, `SrcB`=4. Then BLTU: `Operation`=1100.
- rs1=5 with mem_rd=5 (write, 0xAA) and wb_rd=5 (write, 0xBB): `SrcA`=0xAA. With mem_reg_write=0: 0xBB. With rs1=0 and mem_rd=0: registered value.
- Stall 3 cycles while wb_rd=rs2=7 carries 0x55 in cycle 1 only: `ex_store_data` stays 0x55 after the producer leaves.
- Assert stall and flush together, then reset mid-stall: `ex_valid`=0 and `ex_reg_write`=0 both times. Reset clears outputs without waiting for `clk`.
